// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and fetch constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Clear the byte-offset bits so a redirect always lands on a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry stall buffer and
// FETCH/HOLD/DRAIN control FSM feeding the IF/ID register.
// Optional macro FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
// target raises a sticky misalign_o and stops all further fetching until
// reset; without it the low target bits are simply dropped.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] add_pc_o,
  output logic [31:0] instruction_o,
  output logic        valid_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  add_pc_q, add_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign trap       = misalign_q;
  assign misalign_o = misalign_q;
`else
  assign trap = 1'b0;
`endif

  // The request is dropped while reset is low, while the buffer is full, and
  // for good once a misaligned redirect has trapped. During DRAIN the old
  // address is kept on the bus until memory finishes the abandoned access.
  assign imem_req_o    = rst_i && !trap && (state_q != HOLD);
  assign imem_addr_o   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign add_pc_o      = add_pc_q;
  assign instruction_o = instr_q;
  assign valid_o       = valid_q;

  // Next-state and datapath update; flush takes priority over everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_d        = buf_q;
    add_pc_d     = add_pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif

    if (flush_i) begin
      pc_d    = word_align(branch_target_i);
      instr_d = INSTR_NOP;
      valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (branch_target_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
`endif
      case (state_q)
        FETCH: begin
          if (!(imem_ready_i && !trap)) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end
        HOLD: begin
          state_d = FETCH;
        end
        DRAIN: begin
          if (imem_ready_i && !trap) begin
            state_d = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready_i && !trap) begin
            if (stall_i) begin
              buf_d   = imem_data_i;
              state_d = HOLD;
            end else begin
              add_pc_d = pc_q + PC_STEP;
              instr_d  = imem_data_i;
              valid_d  = 1'b1;
              pc_d     = pc_q + PC_STEP;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            add_pc_d = pc_q + PC_STEP;
            instr_d  = buf_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_STEP;
            state_d  = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready_i && !trap) begin
            state_d = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, drain address, stall buffer and IF/ID output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      buf_q        <= INSTR_NOP;
      add_pc_q     <= 32'h0000_0000;
      instr_q      <= INSTR_NOP;
      valid_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_q        <= buf_d;
      add_pc_q     <= add_pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

endmodule
